gshare_ongorucu_p: RTL and testbench

Parametrised gshare branch predictor with BTB, speculative global history and an in-order in-flight prediction queue. It is the next-generation replacement for the fixed-size predictor driven by the fetch/execute harness. It predicts direction and target at fetch in the same cycle. It checks each prediction against the execute result in fetch order, flags mispredicts, and repairs history on a mispredict.

---
 rtl/gshare_ongorucu_p.sv | 161 ++++++++++++++++
 tb/tb_gshare_ongorucu_p.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/gshare_ongorucu_p.sv
// rtl/gshare_ongorucu_p.sv - gshare direction predictor with direct-mapped BTB and in-order in-flight queue
module gshare_ongorucu_p #(
    parameter int PS_W            = 32,
    parameter int GHR_W           = 8,
    parameter int SAYAC_W         = 2,
    parameter int BTB_DERINLIK    = 16,
    parameter int KUYRUK_DERINLIK = 4
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic [PS_W-1:0]                            getir_ps,
    input  logic [31:0]                                getir_buyruk,
    input  logic                                       getir_gecerli,
    output logic                                       getir_hazir,
    output logic                                       sonuc_dallan,
    output logic [PS_W-1:0]                            sonuc_dallan_ps,
    input  logic [PS_W-1:0]                            yurut_ps,
    input  logic [31:0]                                yurut_buyruk,
    input  logic                                       yurut_dallan,
    input  logic [PS_W-1:0]                            yurut_dallan_ps,
    input  logic                                       yurut_gecerli,
    output logic                                       yurut_hatali,
    output logic [$clog2(KUYRUK_DERINLIK+1)-1:0]       ucusta_sayisi
);

    localparam int BTB_IW = $clog2(BTB_DERINLIK);
    localparam int TAG_W  = PS_W - BTB_IW - 2;
    localparam int PHT_N  = 1 << GHR_W;
    localparam int CNT_W  = $clog2(KUYRUK_DERINLIK + 1);
    localparam int PTR_W  = (KUYRUK_DERINLIK > 1) ? $clog2(KUYRUK_DERINLIK) : 1;

    localparam logic [CNT_W-1:0]   DOLU        = CNT_W'(KUYRUK_DERINLIK);
    localparam logic [PTR_W-1:0]   SON_PTR     = PTR_W'(KUYRUK_DERINLIK - 1);
    localparam logic [SAYAC_W-1:0] SAYAC_MAX   = '1;
    localparam logic [SAYAC_W-1:0] ZAYIF_ALMAZ = {1'b0, {(SAYAC_W-1){1'b1}}};

    typedef enum logic [1:0] {S_DIGER, S_KOSUL, S_ATLA} sinif_t;

    function automatic sinif_t sinif_bul(input logic [6:0] op);
        case (op)
            7'b1100011:             return S_KOSUL;
            7'b1101111, 7'b1100111: return S_ATLA;
            default:                return S_DIGER;
        endcase
    endfunction

    function automatic logic [PTR_W-1:0] ptr_art(input logic [PTR_W-1:0] p);
        return (p == SON_PTR) ? '0 : p + PTR_W'(1);
    endfunction

    logic [SAYAC_W-1:0] pht         [PHT_N];
    logic               btb_gecerli [BTB_DERINLIK];
    logic [TAG_W-1:0]   btb_etiket  [BTB_DERINLIK];
    logic [PS_W-1:0]    btb_hedef   [BTB_DERINLIK];

    logic [GHR_W-1:0]   k_idx   [KUYRUK_DERINLIK];
    logic               k_yon   [KUYRUK_DERINLIK];
    logic [PS_W-1:0]    k_hedef [KUYRUK_DERINLIK];

    logic [GHR_W-1:0]   ghr_spek, ghr_commit, ghr_commit_yeni;
    logic [PTR_W-1:0]   bas, son;
    logic [CNT_W-1:0]   sayi;

    sinif_t             g_sinif, y_sinif;
    logic [GHR_W-1:0]   pht_idx;
    logic [BTB_IW-1:0]  g_btb_idx, y_btb_idx;
    logic               g_hit, tahmin, itme, cekme;
    logic [SAYAC_W-1:0] sayac_eski, sayac_yeni;
    logic [GHR_W:0]     c_kaydir, s_kaydir;
    logic               unused_bitler;

    assign unused_bitler = ^{getir_buyruk[31:7], yurut_buyruk[31:7], getir_ps[1:0], yurut_ps[1:0]};

    assign g_sinif   = sinif_bul(getir_buyruk[6:0]);
    assign y_sinif   = sinif_bul(yurut_buyruk[6:0]);
    assign pht_idx   = getir_ps[GHR_W+1:2] ^ ghr_spek;
    assign g_btb_idx = getir_ps[BTB_IW+1:2];
    assign y_btb_idx = yurut_ps[BTB_IW+1:2];
    assign g_hit     = btb_gecerli[g_btb_idx] && (btb_etiket[g_btb_idx] == getir_ps[PS_W-1:BTB_IW+2]);

    always_comb begin
        tahmin = 1'b0;
        case (g_sinif)
            S_KOSUL: tahmin = pht[pht_idx][SAYAC_W-1] & g_hit;
            S_ATLA:  tahmin = g_hit;
            default: tahmin = 1'b0;
        endcase
    end

    assign getir_hazir     = rst & (sayi < DOLU);
    assign sonuc_dallan    = getir_hazir & tahmin;
    assign sonuc_dallan_ps = sonuc_dallan ? btb_hedef[g_btb_idx] : getir_ps + PS_W'(4);
    assign ucusta_sayisi   = rst ? sayi : '0;

    assign itme  = getir_gecerli & getir_hazir;
    assign cekme = rst & yurut_gecerli & (sayi != '0);
    assign yurut_hatali = cekme & ((yurut_dallan != k_yon[bas]) |
                                   (yurut_dallan & (yurut_dallan_ps != k_hedef[bas])));

    // Shift through a one-wider vector so GHR_W=1 needs no special case.
    assign c_kaydir        = {ghr_commit, yurut_dallan};
    assign s_kaydir        = {ghr_spek, sonuc_dallan};
    assign ghr_commit_yeni = (cekme && y_sinif == S_KOSUL) ? c_kaydir[GHR_W-1:0] : ghr_commit;

    assign sayac_eski = pht[k_idx[bas]];
    always_comb begin
        sayac_yeni = sayac_eski;
        if (yurut_dallan) begin
            if (sayac_eski != SAYAC_MAX) sayac_yeni = sayac_eski + SAYAC_W'(1);
        end else begin
            if (sayac_eski != '0) sayac_yeni = sayac_eski - SAYAC_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < PHT_N; i++) pht[i] <= ZAYIF_ALMAZ;
            for (int i = 0; i < BTB_DERINLIK; i++) btb_gecerli[i] <= 1'b0;
            ghr_spek   <= '0;
            ghr_commit <= '0;
            bas        <= '0;
            son        <= '0;
            sayi       <= '0;
        end else begin
            if (cekme && y_sinif == S_KOSUL) pht[k_idx[bas]] <= sayac_yeni;
            if (cekme && y_sinif != S_DIGER && yurut_dallan) btb_gecerli[y_btb_idx] <= 1'b1;
            ghr_commit <= ghr_commit_yeni;
            // A mispredict drops everything younger, including this cycle's fetch.
            if (yurut_hatali) begin
                ghr_spek <= ghr_commit_yeni;
                bas      <= '0;
                son      <= '0;
                sayi     <= '0;
            end else begin
                if (itme) begin
                    son <= ptr_art(son);
                    if (g_sinif == S_KOSUL) ghr_spek <= s_kaydir[GHR_W-1:0];
                end
                if (cekme) bas <= ptr_art(bas);
                case ({itme, cekme})
                    2'b10:   sayi <= sayi + CNT_W'(1);
                    2'b01:   sayi <= sayi - CNT_W'(1);
                    default: sayi <= sayi;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (itme && !yurut_hatali) begin
            k_idx[son]   <= pht_idx;
            k_yon[son]   <= sonuc_dallan;
            k_hedef[son] <= sonuc_dallan_ps;
        end
        if (cekme && y_sinif != S_DIGER && yurut_dallan) begin
            btb_etiket[y_btb_idx] <= yurut_ps[PS_W-1:BTB_IW+2];
            btb_hedef[y_btb_idx]  <= yurut_dallan_ps;
        end
    end

endmodule

// File: tb/tb_gshare_ongorucu_p.sv
// tb/tb_gshare_ongorucu_p.sv - vector table, corner sequences and random run against a queue-based reference model
module tb_gshare_ongorucu_p;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [31:0] getir_ps, getir_buyruk;
    logic        getir_gecerli, getir_hazir, sonuc_dallan;
    logic [31:0] sonuc_dallan_ps;
    logic [31:0] yurut_ps, yurut_buyruk, yurut_dallan_ps;
    logic        yurut_dallan, yurut_gecerli, yurut_hatali;
    logic [2:0]  ucusta_sayisi;

    gshare_ongorucu_p dut (
        .clk(clk), .rst(rst),
        .getir_ps(getir_ps), .getir_buyruk(getir_buyruk), .getir_gecerli(getir_gecerli),
        .getir_hazir(getir_hazir), .sonuc_dallan(sonuc_dallan), .sonuc_dallan_ps(sonuc_dallan_ps),
        .yurut_ps(yurut_ps), .yurut_buyruk(yurut_buyruk), .yurut_dallan(yurut_dallan),
        .yurut_dallan_ps(yurut_dallan_ps), .yurut_gecerli(yurut_gecerli),
        .yurut_hatali(yurut_hatali), .ucusta_sayisi(ucusta_sayisi)
    );

    localparam logic [31:0] I_K    = 32'h0000_0063;
    localparam logic [31:0] I_JAL  = 32'h0000_006F;
    localparam logic [31:0] I_JALR = 32'h0000_0067;
    localparam logic [31:0] I_OTH  = 32'h0000_0013;

    int n_chk = 0;
    int n_err = 0;

    // Reference model: PHT as integer counters, BTB as arrays, in-flight queue as an SV queue.
    typedef struct { int idx; bit dir; logic [31:0] tgt; } ent_t;
    ent_t        m_q[$];
    int          m_pht[256];
    bit          m_bv[16];
    logic [31:0] m_btag[16];
    logic [31:0] m_btgt[16];
    int          m_ghs, m_ghc;

    bit          a_d, a_hz, a_hat;
    logic [31:0] a_ps, a_cnt0, a_cnt;

    typedef struct {
        bit fv; logic [31:0] fpc, fins;
        bit rv; logic [31:0] rpc, rins; bit rt; logic [31:0] rtgt;
        bit ed; logic [31:0] eps; bit ehat; int ecnt;
    } vec_t;
    vec_t tbl[$];

    task automatic chk(input string ad, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", ad, act, exp);
        end
    endtask

    function automatic int sinif(input logic [31:0] ins);
        case (ins[6:0])
            7'h63:        return 1;
            7'h6F, 7'h67: return 2;
            default:      return 0;
        endcase
    endfunction

    task automatic step(input bit rs, input bit fv, input logic [31:0] fpc, input logic [31:0] fins,
                        input bit rv, input logic [31:0] rpc, input logic [31:0] rins,
                        input bit rt, input logic [31:0] rtgt);
        int fc, rc, idx, bi, rbi;
        bit hit, md, mhz, mhat;
        logic [31:0] mps;
        ent_t h;
        rst = rs; getir_gecerli = fv; getir_ps = fpc; getir_buyruk = fins;
        yurut_gecerli = rv; yurut_ps = rpc; yurut_buyruk = rins;
        yurut_dallan = rt; yurut_dallan_ps = rtgt;
        #2;
        fc  = sinif(fins);
        mhz = rs && (m_q.size() < 4);
        idx = int'((fpc >> 2) & 32'hFF) ^ m_ghs;
        bi  = int'((fpc >> 2) & 32'hF);
        hit = m_bv[bi] && (m_btag[bi] == (fpc >> 6));
        md  = mhz && ((fc == 1 && m_pht[idx] >= 2 && hit) || (fc == 2 && hit));
        mps = md ? m_btgt[bi] : fpc + 32'd4;
        mhat = 1'b0;
        if (rs && rv && m_q.size() > 0) begin
            h = m_q[0];
            mhat = (rt != h.dir) || (rt && rtgt != h.tgt);
        end
        a_d = sonuc_dallan; a_ps = sonuc_dallan_ps; a_hz = getir_hazir;
        a_hat = yurut_hatali; a_cnt0 = 32'(ucusta_sayisi);
        chk("model_hazir", 32'(a_hz), 32'(mhz));
        chk("model_dallan", 32'(a_d), 32'(md));
        chk("model_dallan_ps", a_ps, mps);
        chk("model_hatali", 32'(a_hat), 32'(mhat));
        chk("model_ucusta_once", a_cnt0, rs ? m_q.size() : 0);
        @(posedge clk);
        if (!rs) begin
            m_q.delete();
            m_ghs = 0; m_ghc = 0;
            foreach (m_pht[i]) m_pht[i] = 1;
            foreach (m_bv[i]) m_bv[i] = 1'b0;
        end else begin
            if (rv && m_q.size() > 0) begin
                h   = m_q.pop_front();
                rc  = sinif(rins);
                rbi = int'((rpc >> 2) & 32'hF);
                if (rc == 1) begin
                    if (rt) m_pht[h.idx] = (m_pht[h.idx] == 3) ? 3 : m_pht[h.idx] + 1;
                    else    m_pht[h.idx] = (m_pht[h.idx] == 0) ? 0 : m_pht[h.idx] - 1;
                    m_ghc = ((m_ghc << 1) | int'(rt)) & 255;
                end
                if (rc != 0 && rt) begin
                    m_bv[rbi] = 1'b1; m_btag[rbi] = rpc >> 6; m_btgt[rbi] = rtgt;
                end
                if (mhat) begin
                    m_q.delete();
                    m_ghs = m_ghc;
                end
            end
            if (!mhat && fv && mhz) begin
                m_q.push_back('{idx, md, mps});
                if (fc == 1) m_ghs = ((m_ghs << 1) | int'(md)) & 255;
            end
        end
        #1;
        a_cnt = 32'(ucusta_sayisi);
        chk("model_ucusta", a_cnt, m_q.size());
    endtask

    function automatic void vf(logic [31:0] pc, logic [31:0] ins, bit ed, logic [31:0] eps);
        tbl.push_back('{1'b1, pc, ins, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, ed, eps, 1'b0, 1});
    endfunction

    function automatic void vr(logic [31:0] pc, logic [31:0] ins, bit rt, logic [31:0] tgt, bit ehat);
        tbl.push_back('{1'b0, 32'h204, I_OTH, 1'b1, pc, ins, rt, tgt, 1'b0, 32'h208, ehat, 0});
    endfunction

    logic [31:0] r_pcs[6]  = '{32'h100, 32'h104, 32'h200, 32'h204, 32'h1100, 32'h340};
    logic [31:0] r_ins[4]  = '{I_K, I_JAL, I_JALR, I_OTH};
    logic [31:0] r_tgts[4] = '{32'h80, 32'h40, 32'h300, 32'h104};

    initial begin
        // Fresh history indices each time until the history saturates at all ones.
        for (int k = 0; k < 9; k++) begin
            vf(32'h100, I_K, 1'b0, 32'h104);
            vr(32'h100, I_K, 1'b1, 32'h80, 1'b1);
        end
        // Counter 2 -> 3 -> stays 3: three taken predictions in a row.
        for (int k = 0; k < 3; k++) begin
            vf(32'h100, I_K, 1'b1, 32'h80);
            vr(32'h100, I_K, 1'b1, 32'h80, 1'b0);
        end
        vf(32'h100, I_K, 1'b1, 32'h80);    vr(32'h100, I_K, 1'b0, 32'h104, 1'b1);
        vf(32'h200, I_JAL, 1'b0, 32'h204); vr(32'h200, I_JAL, 1'b1, 32'h40, 1'b1);
        vf(32'h200, I_JAL, 1'b1, 32'h40);  vr(32'h200, I_JAL, 1'b1, 32'h40, 1'b0);
        vf(32'h200, I_JALR, 1'b1, 32'h40); vr(32'h200, I_JALR, 1'b1, 32'h40, 1'b0);
        vf(32'h200, I_JAL, 1'b1, 32'h40);  vr(32'h200, I_JAL, 1'b1, 32'h44, 1'b1);
        vf(32'h100, I_K, 1'b0, 32'h104);   vr(32'h100, I_K, 1'b0, 32'h0, 1'b0);
        vf(32'h204, I_OTH, 1'b0, 32'h208); vr(32'h204, I_OTH, 1'b0, 32'h0, 1'b0);

        step(0, 1, 32'h100, I_JAL, 1, 32'h100, I_K, 1, 32'h80);
        chk("rst_hazir", 32'(a_hz), 0);
        chk("rst_dallan", 32'(a_d), 0);
        chk("rst_ps", a_ps, 32'h104);
        chk("rst_hatali", 32'(a_hat), 0);
        chk("rst_ucusta", a_cnt, 0);
        step(0, 0, 32'h100, I_K, 0, 32'h0, 32'h0, 0, 32'h0);

        for (int i = 0; i < tbl.size(); i++) begin
            step(1, tbl[i].fv, tbl[i].fpc, tbl[i].fins, tbl[i].rv, tbl[i].rpc, tbl[i].rins, tbl[i].rt, tbl[i].rtgt);
            chk($sformatf("vec%0d_dallan", i), 32'(a_d), 32'(tbl[i].ed));
            chk($sformatf("vec%0d_ps", i), a_ps, tbl[i].eps);
            chk($sformatf("vec%0d_hatali", i), 32'(a_hat), 32'(tbl[i].ehat));
            chk($sformatf("vec%0d_ucusta", i), a_cnt, tbl[i].ecnt);
        end

        // Full queue: no push while full, even with a same-cycle pop.
        for (int i = 0; i < 4; i++) begin
            step(1, 1, 32'h204, I_OTH, 0, 32'h0, 32'h0, 0, 32'h0);
            chk("dolu_doldur", a_cnt, i + 1);
        end
        step(1, 1, 32'h200, I_JAL, 0, 32'h0, 32'h0, 0, 32'h0);
        chk("dolu_hazir", 32'(a_hz), 0);
        chk("dolu_dallan", 32'(a_d), 0);
        chk("dolu_ps", a_ps, 32'h204);
        chk("dolu_itme_yok", a_cnt, 4);
        step(1, 1, 32'h204, I_OTH, 1, 32'h204, I_OTH, 0, 32'h0);
        chk("dolu_cek_itme", a_cnt, 3);
        step(1, 1, 32'h204, I_OTH, 1, 32'h204, I_OTH, 0, 32'h0);
        chk("hazir_geri", 32'(a_hz), 1);
        chk("itme_cekme_sabit", a_cnt, 3);
        for (int i = 0; i < 3; i++) step(1, 0, 32'h204, I_OTH, 1, 32'h204, I_OTH, 0, 32'h0);
        chk("bosalt", a_cnt, 0);

        // Head mispredict with a fetch presented, then a resolve on the empty queue.
        for (int i = 0; i < 3; i++) step(1, 1, 32'h100, I_K, 0, 32'h0, 32'h0, 0, 32'h0);
        chk("ucuz_uc", a_cnt, 3);
        step(1, 1, 32'h100, I_K, 1, 32'h100, I_K, 1, 32'h80);
        chk("temizle_hatali", 32'(a_hat), 1);
        chk("temizle_ucusta", a_cnt, 0);
        step(1, 0, 32'h204, I_OTH, 1, 32'h100, I_K, 1, 32'h300);
        chk("bos_cekme_hatali", 32'(a_hat), 0);
        chk("bos_cekme_ucusta", a_cnt, 0);
        step(1, 1, 32'h100, I_JAL, 0, 32'h0, 32'h0, 0, 32'h0);
        chk("bos_cekme_btb_d", 32'(a_d), 1);
        chk("bos_cekme_btb_ps", a_ps, 32'h80);
        step(1, 0, 32'h204, I_OTH, 1, 32'h100, I_JAL, 1, 32'h80);
        chk("atla_dogru", 32'(a_hat), 0);

        // Mid-stream reset with two entries in flight.
        step(1, 1, 32'h204, I_OTH, 0, 32'h0, 32'h0, 0, 32'h0);
        step(1, 1, 32'h204, I_OTH, 0, 32'h0, 32'h0, 0, 32'h0);
        chk("ara_rst_once", a_cnt, 2);
        step(0, 1, 32'h100, I_JAL, 1, 32'h204, I_OTH, 1, 32'h300);
        chk("ara_rst_hazir", 32'(a_hz), 0);
        chk("ara_rst_dallan", 32'(a_d), 0);
        chk("ara_rst_ps", a_ps, 32'h104);
        chk("ara_rst_hatali", 32'(a_hat), 0);
        chk("ara_rst_ucusta_comb", a_cnt0, 0);
        chk("ara_rst_ucusta", a_cnt, 0);
        step(1, 1, 32'h100, I_JAL, 0, 32'h0, 32'h0, 0, 32'h0);
        chk("btb_soguk_d", 32'(a_d), 0);
        chk("btb_soguk_ps", a_ps, 32'h104);
        step(1, 0, 32'h204, I_OTH, 1, 32'h100, I_JAL, 1, 32'h80);
        chk("btb_soguk_hatali", 32'(a_hat), 1);
        step(1, 1, 32'h100, I_K, 0, 32'h0, 32'h0, 0, 32'h0);
        chk("pht_zayif_d", 32'(a_d), 0);
        chk("pht_zayif_ps", a_ps, 32'h104);
        step(1, 0, 32'h204, I_OTH, 1, 32'h100, I_K, 0, 32'h0);
        chk("pht_zayif_hatali", 32'(a_hat), 0);

        for (int n = 0; n < 1500; n++) begin
            step($urandom_range(0, 63) != 0, $urandom_range(0, 3) != 0,
                 r_pcs[$urandom_range(0, 5)], r_ins[$urandom_range(0, 3)],
                 $urandom_range(0, 2) != 0, r_pcs[$urandom_range(0, 5)], r_ins[$urandom_range(0, 3)],
                 $urandom_range(0, 1) != 0, r_tgts[$urandom_range(0, 3)]);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
